// File: rtl/quadram_arbiter.sv
// quadram_arbiter
// Time-shares one quadram port between two requesters (0 = subsurf engine,
// 1 = host loader/readback). Grants are round-robin, a requester may lock the
// port for a burst, and a locked burst is bounded to MAX_BURST consecutive
// grants while the other side is waiting.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   req0/1, lock0/1     request this cycle / ask to keep the port next cycle
//   we0/1, addr0/1      byte write enables (0 = read) and word address
//   din0/1              write data
//   gnt0/1              access performed this cycle (combinational)
//   rvalid0/1, rdata    read data return, one cycle after a read grant
//   ram_en/we/addr/din  command to the quadram
//   ram_dout            quadram read data, valid one cycle after a read
module quadram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [3:0]            we0,
  input  logic [3:0]            we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic       rrLast_q,    rrLast_d;
  logic       holdValid_q, holdValid_d;
  logic       holdId_q,    holdId_d;
  logic [7:0] burstCnt_q,  burstCnt_d;
  logic       rvalid0_q,   rvalid0_d;
  logic       rvalid1_q,   rvalid1_d;

  logic       reqAny;
  logic       gntValid;
  logic       gntId;
  logic       reqOther;
  logic       lockOwn;
  logic       breakHold;

  // Grant selection: an active hold wins, then a lone requester, then the
  // side that was not granted last. Everything is gated off during reset.
  always_comb begin
    reqAny = 1'b0;
    gntId  = 1'b0;
    if (holdValid_q && (holdId_q ? req1 : req0)) begin
      reqAny = 1'b1;
      gntId  = holdId_q;
    end else if (req0 && !req1) begin
      reqAny = 1'b1;
      gntId  = 1'b0;
    end else if (req1 && !req0) begin
      reqAny = 1'b1;
      gntId  = 1'b1;
    end else if (req0 && req1) begin
      reqAny = 1'b1;
      gntId  = ~rrLast_q;
    end
    gntValid = reqAny & rst_n;
  end

  assign gnt0 = gntValid & ~gntId;
  assign gnt1 = gntValid &  gntId;

  // The owner's command goes straight to the quadram; an idle port drives zeros.
  always_comb begin
    ram_en   = gntValid;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (gntValid) begin
      ram_we   = gntId ? we1   : we0;
      ram_addr = gntId ? addr1 : addr0;
      ram_din  = gntId ? din1  : din0;
    end
  end

  assign rdata   = ram_dout;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

  // Next-state: the burst counter saturates so a long unopposed lock never
  // wraps; the hold is dropped only once the bound is reached and the other
  // side is actually waiting.
  always_comb begin
    rrLast_d    = rrLast_q;
    holdId_d    = holdId_q;
    burstCnt_d  = burstCnt_q;
    holdValid_d = 1'b0;
    reqOther    = gntId ? req0  : req1;
    lockOwn     = gntId ? lock1 : lock0;
    breakHold   = 1'b0;
    if (gntValid) begin
      rrLast_d = gntId;
      holdId_d = gntId;
      if (holdValid_q && (holdId_q == gntId)) begin
        burstCnt_d = (burstCnt_q == 8'hFF) ? 8'hFF : burstCnt_q + 8'd1;
      end else begin
        burstCnt_d = 8'd1;
      end
      breakHold   = (burstCnt_d >= 8'(MAX_BURST)) && reqOther;
      holdValid_d = lockOwn && !breakHold;
    end
    rvalid0_d = gnt0 && (we0 == 4'b0000);
    rvalid1_d = gnt1 && (we1 == 4'b0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrLast_q    <= 1'b1;
      holdValid_q <= 1'b0;
      holdId_q    <= 1'b0;
      burstCnt_q  <= 8'd0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      rrLast_q    <= rrLast_d;
      holdValid_q <= holdValid_d;
      holdId_q    <= holdId_d;
      burstCnt_q  <= burstCnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

endmodule

// File: tb/tb_quadram_arbiter.sv
// Testbench for quadram_arbiter: a behavioural quadram stub plus a reference
// model of the arbitration rules and a shadow memory for expected read data.
module tb_quadram_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [3:0]    we0 = '0, we1 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_en;
  logic [DW-1:0] rdata, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;

  int testsRun = 0;
  int failCount = 0;

  // Reference model state: last granted side, current hold owner (-1 = none),
  // length of the current locked run, and the read data owed next cycle.
  int          mLast, mHold, mStreak;
  bit          mPend0, mPend1;
  logic [31:0] mPendData;
  logic [31:0] shadow [0:2047];

  quadram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(int i);
    if (i == 3) return 32'h3333_3333;
    if (i == 5) return 32'h1234_5678;
    if (i == 7) return 32'h1122_3344;
    return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Quadram stub: synchronous read, byte-lane writes.
  initial begin : ramStub
    logic [31:0] ramMem [0:2047];
    for (int i = 0; i < 2048; i++) ramMem[i] = initWord(i);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we == 4'b0000) begin
          ram_dout <= ramMem[ram_addr];
        end else begin
          for (int b = 0; b < 4; b++)
            if (ram_we[b]) ramMem[ram_addr][b*8 +: 8] = ram_din[b*8 +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare mid-cycle, then let
  // the model advance past the rising edge.
  task automatic applyStimulus(
    input bit r0, input bit l0, input logic [3:0] w0, input logic [10:0] a0, input logic [31:0] d0,
    input bit r1, input bit l1, input logic [3:0] w1, input logic [10:0] a1, input logic [31:0] d1,
    output int g, output bit rv0, output bit rv1, output logic [31:0] rd);
    bit reqs [2];
    bit locks [2];
    logic [3:0] wes [2];
    logic [10:0] adrs [2];
    logic [31:0] dins [2];
    logic [3:0] expWe;
    logic [10:0] expAddr;
    logic [31:0] expDin;
    @(negedge clk);
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; din1 = d1;
    reqs[0] = r0; reqs[1] = r1; locks[0] = l0; locks[1] = l1;
    wes[0] = w0; wes[1] = w1; adrs[0] = a0; adrs[1] = a1; dins[0] = d0; dins[1] = d1;
    #1;
    rv0 = rvalid0; rv1 = rvalid1; rd = rdata;
    if (mHold >= 0 && reqs[mHold]) g = mHold;
    else if (r0 && !r1) g = 0;
    else if (r1 && !r0) g = 1;
    else if (r0 && r1) g = 1 - mLast;
    else g = -1;
    expWe = 4'b0; expAddr = '0; expDin = '0;
    if (g >= 0) begin expWe = wes[g]; expAddr = adrs[g]; expDin = dins[g]; end
    checkOutput("gnt0", gnt0, g == 0);
    checkOutput("gnt1", gnt1, g == 1);
    checkOutput("ram_en", ram_en, g >= 0);
    checkOutput("ram_we", ram_we, expWe);
    checkOutput("ram_addr", ram_addr, expAddr);
    checkOutput("ram_din", ram_din, expDin);
    checkOutput("rvalid0", rvalid0, mPend0);
    checkOutput("rvalid1", rvalid1, mPend1);
    if (mPend0 || mPend1) checkOutput("rdata", rdata, mPendData);
    mPend0 = 0; mPend1 = 0;
    if (g >= 0) begin
      mStreak = (mHold == g) ? mStreak + 1 : 1;
      mLast = g;
      mHold = (locks[g] && !(mStreak >= MB && reqs[1-g])) ? g : -1;
      if (wes[g] == 4'b0000) begin
        if (g == 0) mPend0 = 1; else mPend1 = 1;
        mPendData = shadow[adrs[g]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wes[g][b]) shadow[adrs[g]][b*8 +: 8] = dins[g][b*8 +: 8];
      end
    end else begin
      mHold = -1;
    end
    @(posedge clk);
  endtask

  // Reset pulse asserted between edges: outputs must drop immediately even
  // with both requests active.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 4'hF; we1 = 4'h0;
    #1;
    checkOutput("rst_gnt0", gnt0, 1'b0);
    checkOutput("rst_gnt1", gnt1, 1'b0);
    checkOutput("rst_ram_en", ram_en, 1'b0);
    checkOutput("rst_ram_we", ram_we, 4'b0);
    checkOutput("rst_rvalid0", rvalid0, 1'b0);
    checkOutput("rst_rvalid1", rvalid1, 1'b0);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; we0 = '0; we1 = '0;
    rst_n = 1'b1;
    mLast = 1; mHold = -1; mStreak = 0; mPend0 = 0; mPend1 = 0; mPendData = '0;
  endtask

  initial begin
    int g;
    bit rv0, rv1;
    logic [31:0] rd;
    for (int i = 0; i < 2048; i++) shadow[i] = initWord(i);
    doReset();

    // Single read by requester 0.
    applyStimulus(1,0,4'h0,11'd5,32'h0, 0,0,4'h0,11'd0,32'h0, g,rv0,rv1,rd);
    checkOutput("t1_gnt", g, 0);
    applyStimulus(0,0,4'h0,11'd0,32'h0, 0,0,4'h0,11'd0,32'h0, g,rv0,rv1,rd);
    checkOutput("t1_rvalid0", rv0, 1'b1);
    checkOutput("t1_rvalid1", rv1, 1'b0);
    checkOutput("t1_rdata", rd, 32'h1234_5678);

    // Round-robin between two continuous readers.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1,0,4'h0,11'(10+i),32'h0, 1,0,4'h0,11'(20+i),32'h0, g,rv0,rv1,rd);
      checkOutput("t2_gnt", g, i % 2);
    end

    // Locked burst against a waiting requester, then unopposed.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1,1,4'h0,11'd1,32'h0, 1,0,4'h0,11'd2,32'h0, g,rv0,rv1,rd);
      checkOutput("t3_burst_gnt", g, (i == 16) ? 1 : 0);
    end
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1,1,4'h0,11'd1,32'h0, 0,0,4'h0,11'd2,32'h0, g,rv0,rv1,rd);
      checkOutput("t3_solo_gnt", g, 0);
    end

    // Partial byte-lane write then read back.
    applyStimulus(0,0,4'h0,11'd0,32'h0, 1,0,4'b0011,11'd7,32'hAABB_CCDD, g,rv0,rv1,rd);
    applyStimulus(0,0,4'h0,11'd0,32'h0, 1,0,4'h0,11'd7,32'h0, g,rv0,rv1,rd);
    checkOutput("t4_write_rvalid1", rv1, 1'b0);
    applyStimulus(0,0,4'h0,11'd0,32'h0, 0,0,4'h0,11'd0,32'h0, g,rv0,rv1,rd);
    checkOutput("t4_rvalid1", rv1, 1'b1);
    checkOutput("t4_rdata", rd, 32'h1122_CCDD);

    // Reset in the middle of a locked read burst.
    applyStimulus(0,0,4'h0,11'd0,32'h0, 1,1,4'h0,11'd20,32'h0, g,rv0,rv1,rd);
    applyStimulus(0,0,4'h0,11'd0,32'h0, 1,1,4'h0,11'd21,32'h0, g,rv0,rv1,rd);
    doReset();
    applyStimulus(1,0,4'h0,11'd30,32'h0, 1,0,4'h0,11'd31,32'h0, g,rv0,rv1,rd);
    checkOutput("t5_first_gnt", g, 0);

    // Write/read collision on address 3 with rr_last = 0.
    applyStimulus(1,0,4'hF,11'd3,32'hDEAD_BEEF, 1,0,4'h0,11'd3,32'h0, g,rv0,rv1,rd);
    checkOutput("t6_winner", g, 1);
    applyStimulus(1,0,4'hF,11'd3,32'hDEAD_BEEF, 0,0,4'h0,11'd0,32'h0, g,rv0,rv1,rd);
    checkOutput("t6_stalled_write", g, 0);
    checkOutput("t6_old_data", rd, 32'h3333_3333);
    applyStimulus(0,0,4'h0,11'd0,32'h0, 1,0,4'h0,11'd3,32'h0, g,rv0,rv1,rd);
    applyStimulus(0,0,4'h0,11'd0,32'h0, 0,0,4'h0,11'd0,32'h0, g,rv0,rv1,rd);
    checkOutput("t6_new_data", rd, 32'hDEAD_BEEF);

    // Requester 0 locked continuously while requester 1 comes and goes.
    for (int i = 0; i < 120; i++)
      applyStimulus(1,1,4'h0,11'($urandom_range(15)),32'h0,
                    bit'($urandom_range(1)),0,4'h0,11'($urandom_range(15)),32'h0, g,rv0,rv1,rd);

    // Fully random traffic on a small address window.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(99) == 0) doReset();
      applyStimulus(bit'($urandom_range(99) < 75), bit'($urandom_range(99) < 80),
                    ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15)),
                    11'($urandom_range(15)), $urandom,
                    bit'($urandom_range(99) < 75), bit'($urandom_range(99) < 80),
                    ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15)),
                    11'($urandom_range(15)), $urandom,
                    g, rv0, rv1, rd);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
